// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. Multiplies by shift-add and divides
// by restoring shift-subtract, one bit per cycle, on operand magnitudes; the
// result sign is applied once at the end. Execute is stalled while the unit
// iterates, and the result is presented with a one-cycle done strobe.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic                  flush,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic [1:0]     state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     op_reg;
    logic           neg_reg;
    logic [W-1:0]   opnd_reg;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0] prod_reg;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   result_reg;

    // Start-time decode: operand magnitudes, result sign and the early-out cases
    logic           a_neg, b_neg, neg_start;
    logic [W-1:0]   mag_a, mag_b;
    logic           div_zero, div_ovf, special;
    logic [W-1:0]   special_res;
    logic           accept;

    // Decode the incoming operation in the cycle it is offered
    always_comb begin
        a_neg     = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM)) && rs1[W-1];
        b_neg     = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && rs2[W-1];
        mag_a     = a_neg ? (~rs1 + 1'b1) : rs1;
        mag_b     = b_neg ? (~rs2 + 1'b1) : rs2;
        // Remainder follows the dividend; product and quotient follow sign(A)^sign(B)
        neg_start = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = op[2] && (rs2 == '0);
        div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                    (rs1 == {1'b1, {(W-1){1'b0}}}) && (rs2 == '1);
        special   = div_zero || div_ovf;
        if (div_zero)
            special_res = op[1] ? rs1 : '1;
        else
            special_res = op[1] ? '0 : rs1;
        accept    = (state_reg == ST_IDLE) && start && !flush;
    end

    // One iteration step of both datapaths plus final sign/half selection
    logic [W:0]     mul_acc;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fin;
    logic [W-1:0]   mul_res, div_raw, div_res, calc_res;

    // Combinational iteration and final result formation
    always_comb begin
        mul_acc   = {1'b0, prod_reg[2*W-1:W]} + ({1'b0, opnd_reg} & {(W+1){prod_reg[0]}});
        mul_next  = {mul_acc, prod_reg[W-1:1]};
        div_shift = {prod_reg[2*W-1:W], prod_reg[W-1]};
        div_ge    = div_shift >= {1'b0, opnd_reg};
        // The difference always fits in W bits because the remainder stays below the divisor
        div_rem   = div_ge ? (div_shift[W-1:0] - opnd_reg) : div_shift[W-1:0];
        div_next  = {div_rem, prod_reg[W-2:0], div_ge};
        prod_fin  = neg_reg ? (~mul_next + 1'b1) : mul_next;
        mul_res   = (op_reg[1:0] == 2'b00) ? prod_fin[W-1:0] : prod_fin[2*W-1:W];
        div_raw   = op_reg[1] ? div_next[2*W-1:W] : div_next[W-1:0];
        div_res   = neg_reg ? (~div_raw + 1'b1) : div_raw;
        calc_res  = op_reg[2] ? div_res : mul_res;
    end

    // Sequencer state, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            opnd_reg   <= '0;
            prod_reg   <= '0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg  <= op;
                        neg_reg <= neg_start;
                        cnt_reg <= '0;
                        if (special) begin
                            result_reg <= special_res;
                            state_reg  <= ST_DONE;
                        end else begin
                            opnd_reg  <= op[2] ? mag_b : mag_a;
                            prod_reg  <= {{W{1'b0}}, (op[2] ? mag_a : mag_b)};
                            state_reg <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    prod_reg <= op_reg[2] ? div_next : mul_next;
                    if (cnt_reg == CW'(W - 1)) begin
                        cnt_reg    <= '0;
                        result_reg <= calc_res;
                        state_reg  <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Stall covers the accepting cycle and all iterations; done marks the result cycle
    always_comb begin
        stall  = rst_n && (accept || (state_reg == ST_CALC));
        done   = (state_reg == ST_DONE);
        result = result_reg;
    end
endmodule
